frame_memory_reader: RTL and testbench
======================================

# frame_memory_reader

Read-side controller for the frame memory: on a start pulse it walks one frame stored as packed 96-bit words (four 24bpp pixels per word) and streams it out through a valid/ready interface with frame/line markers. It drives the frame memory's synchronous SRAM port (CSN/WEN/ADDR, DOUT one cycle later) and absorbs downstream backpressure with a small credit-controlled output FIFO. It is the counterpart of the memory write path and sits between the frame memory and the display/pixel pipeline.

## Interface
- DATA_WIDTH, 96, memory word width (4 pixels × 24 bpp)
- ADDR_WIDTH, 16, memory address width
- H_WORDS, 80, words per active line (320 px / 4)
- V_LINES, 240, active lines per frame
- LINE_STRIDE, 128, address step between lines (512 px / 4)
- CLK  in  1  single clock, all logic on rising edge
- RST  in  1  asynchronous, active-high reset
- START  in  1  one-cycle pulse, begin reading a frame
- BASE_ADDR  in  ADDR_WIDTH  frame base address (present only with FRM_RD_BASE_EN)
- BUSY  out  1  high from accepted START until DONE
- DONE  out  1  one-cycle pulse after last word handshake
- CSN  out  1  memory chip select, active low
- WEN  out  1  memory write enable, active low; held 1 (read-only)
- ADDR  out  ADDR_WIDTH  memory read address
- DOUT  in  DATA_WIDTH  memory read data, valid the cycle after CSN low
- ODATA  out  DATA_WIDTH  output word
- OVALID  out  1  output word valid
- ORDY  in  1  downstream ready
- OSOF  out  1  qualifies first word of frame
- OEOL  out  1  qualifies last word of each line
- OEOF  out  1  qualifies last word of frame

## Operation
- States: IDLE, READ, DRAIN. IDLE→READ on START (base latched, col/line counters cleared). READ→DRAIN after last read issued. DRAIN→IDLE when FIFO empty and no read in flight; DONE pulses on that transition. START outside IDLE ignored.
- Read issue (READ only): CSN=0 with ADDR=base+line×LINE_STRIDE+col when (fifo_count + inflight) < 4; otherwise CSN=1. inflight is a 1-bit flag of the read issued last cycle.
- Address arithmetic computed in ADDR_WIDTH bits, wraps modulo 2^ADDR_WIDTH.
- col increments per issued read; at H_WORDS-1 wraps to 0 and line increments; last read at line V_LINES-1, col H_WORDS-1.
- Each returned DOUT pushed into 4-entry FIFO together with SOF/EOL/EOF tags computed at issue time and delayed one cycle alongside the read.
- FIFO head drives ODATA/OSOF/OEOL/OEOF; OVALID = FIFO not empty. Pop on OVALID&ORDY. Push and pop in the same cycle allowed; the credit rule guarantees no overflow.
- Output stable while OVALID&!ORDY.

## Timing
- Reset values: BUSY=0, DONE=0, CSN=1, WEN=1, ADDR=0, OVALID=0, ODATA=0, OSOF/OEOL/OEOF=0; FIFO emptied, state IDLE.
- START sampled at edge E0 → CSN=0 with first ADDR in cycle after E0; data captured at E2; OVALID=1 after E2 (3-cycle first-word latency).
- With ORDY held high: one word per cycle sustained, no CSN bubbles.
- BUSY rises the cycle after START; falls with DONE pulse, one cycle after final handshake.
- RST mid-frame: immediate return to reset values; partial frame discarded; in-flight DOUT ignored.

## Configuration
- FRM_RD_BASE_EN defined: BASE_ADDR port exists, latched on accepted START (double-buffering support).
- Undefined: no BASE_ADDR port; base fixed at 0.

## Structure
- Package frame_mem_pkg: DATA_WIDTH/ADDR_WIDTH/H_WORDS/V_LINES/LINE_STRIDE defaults, state enum type, word-tag struct (sof, eol, eof).
- Sub-module fmr_out_fifo: 4-entry synchronous FIFO carrying data plus tags, count output, async active-high reset.

## Test plan
- Full frame, ORDY=1: 19200 words, ADDRs 0..79, 128..207, …, last 30671; OSOF on word 1, OEOL every 80th, OEOF on word 19200; DONE one cycle later; ODATA matches preloaded memory.
- Random ORDY (50%): identical data/tag sequence, no duplicates or losses, CSN held high whenever count+inflight=4, ODATA stable while stalled.
- START pulsed while BUSY: ignored; single frame, single DONE.
- RST asserted at word 5000: all outputs to reset values next cycle; new START reads from address 0 with OSOF.
- FRM_RD_BASE_EN, BASE_ADDR=0x8000: first ADDR 0x8000; BASE_ADDR=0xFFF0: second line starts at 0x0070 (wrap).
- Small-parameter build (H_WORDS=2, V_LINES=2): 4 words, OEOL on words 2 and 4, OEOF on word 4.

Source files
------------

// File: rtl/frame_mem_pkg.sv
// Shared definitions for the frame memory read path: default geometry,
// reader state type and the per-word frame/line marker tags.
package frame_mem_pkg;

    localparam int DEFAULT_DATA_WIDTH  = 96;
    localparam int DEFAULT_ADDR_WIDTH  = 16;
    localparam int DEFAULT_H_WORDS     = 80;
    localparam int DEFAULT_V_LINES     = 240;
    localparam int DEFAULT_LINE_STRIDE = 128;
    localparam int FIFO_DEPTH          = 4;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } fmr_state_t;

    typedef struct packed {
        logic sof;
        logic eol;
        logic eof;
    } word_tag_t;

endpackage

// File: rtl/fmr_out_fifo.sv
// Four-entry output FIFO holding memory words plus their frame/line tags;
// the head entry is presented directly on the outputs.
module fmr_out_fifo
    import frame_mem_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  word_tag_t             push_tag,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output word_tag_t             head_tag,
    output logic [2:0]            count
);

    logic [DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];
    word_tag_t             tag_mem  [FIFO_DEPTH];
    logic [1:0]            wr_ptr;
    logic [1:0]            rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_pop  = pop && (count != 3'd0);
    assign do_push = push && ((count != 3'(FIFO_DEPTH)) || do_pop);

    assign head_data = data_mem[rd_ptr];
    assign head_tag  = tag_mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_mem[i] <= '0;
                tag_mem[i]  <= '0;
            end
        end else begin
            if (do_push) begin
                data_mem[wr_ptr] <= push_data;
                tag_mem[wr_ptr]  <= push_tag;
                wr_ptr           <= wr_ptr + 2'd1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/frame_memory_reader.sv
// Frame memory read controller: walks one frame of packed words out of the
// synchronous SRAM and streams it with SOF/EOL/EOF markers over valid/ready.
// Define FRM_RD_BASE_EN to add the base_addr port (latched on accepted start).
module frame_memory_reader
    import frame_mem_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int H_WORDS     = DEFAULT_H_WORDS,
    parameter int V_LINES     = DEFAULT_V_LINES,
    parameter int LINE_STRIDE = DEFAULT_LINE_STRIDE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
`ifdef FRM_RD_BASE_EN
    input  logic [ADDR_WIDTH-1:0] base_addr,
`endif
    output logic                  busy,
    output logic                  done,
    output logic                  csn,
    output logic                  wen,
    output logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] dout,
    output logic [DATA_WIDTH-1:0] odata,
    output logic                  ovalid,
    input  logic                  ordy,
    output logic                  osof,
    output logic                  oeol,
    output logic                  oeof
);

    localparam int COL_W  = (H_WORDS > 1) ? $clog2(H_WORDS) : 1;
    localparam int LINE_W = (V_LINES > 1) ? $clog2(V_LINES) : 1;
    localparam logic [COL_W-1:0]      COL_LAST  = COL_W'(H_WORDS - 1);
    localparam logic [LINE_W-1:0]     LINE_LAST = LINE_W'(V_LINES - 1);
    localparam logic [ADDR_WIDTH-1:0] STRIDE    = ADDR_WIDTH'(LINE_STRIDE);

    fmr_state_t            state;
    fmr_state_t            state_next;
    logic [COL_W-1:0]      col;
    logic [LINE_W-1:0]     line;
    logic [ADDR_WIDTH-1:0] line_addr;
    logic [ADDR_WIDTH-1:0] frame_base;
    logic                  inflight;
    word_tag_t             issue_tag;
    word_tag_t             inflight_tag;
    word_tag_t             head_tag;
    logic [2:0]            fifo_count;
    logic                  issue;
    logic                  last_word;
    logic                  pop;

`ifdef FRM_RD_BASE_EN
    assign frame_base = base_addr;
`else
    assign frame_base = '0;
`endif

    // Credit check counts the word still on its way back from the SRAM,
    // so the FIFO can never be asked to take a fifth entry.
    assign issue     = (state == READ) && ((fifo_count + {2'b00, inflight}) < 3'(FIFO_DEPTH));
    assign last_word = (col == COL_LAST) && (line == LINE_LAST);
    assign csn       = ~issue;
    assign wen       = 1'b1;
    assign addr      = issue ? (line_addr + ADDR_WIDTH'(col)) : '0;
    assign busy      = (state != IDLE);

    always_comb begin
        issue_tag     = '0;
        issue_tag.sof = (col == '0) && (line == '0);
        issue_tag.eol = (col == COL_LAST);
        issue_tag.eof = last_word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // done fires on the DRAIN exit, i.e. once the final word has been accepted.
    always_comb begin
        state_next = state;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = READ;
                end
            end
            READ: begin
                if (issue && last_word) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if ((fifo_count == 3'd0) && !inflight) begin
                    state_next = IDLE;
                    done       = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // line_addr carries base + line*stride so each read only adds the column.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col          <= '0;
            line         <= '0;
            line_addr    <= '0;
            inflight     <= 1'b0;
            inflight_tag <= '0;
        end else begin
            inflight     <= issue;
            inflight_tag <= issue_tag;
            if ((state == IDLE) && start) begin
                col       <= '0;
                line      <= '0;
                line_addr <= frame_base;
            end else if (issue) begin
                if (col == COL_LAST) begin
                    col       <= '0;
                    line      <= line + LINE_W'(1);
                    line_addr <= line_addr + STRIDE;
                end else begin
                    col <= col + COL_W'(1);
                end
            end
        end
    end

    assign pop = ovalid && ordy;

    fmr_out_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data (dout),
        .push_tag  (inflight_tag),
        .pop       (pop),
        .head_data (odata),
        .head_tag  (head_tag),
        .count     (fifo_count)
    );

    assign ovalid = (fifo_count != 3'd0);
    assign osof   = head_tag.sof;
    assign oeol   = head_tag.eol;
    assign oeof   = head_tag.eof;

endmodule

// File: tb/tb_frame_memory_reader.sv
// Self-checking bench for frame_memory_reader: SRAM model, random backpressure,
// and a frame-level reference model of the address and word/tag sequence.
module tb_frame_memory_reader;

    localparam int DW = 96;
    localparam int AW = 16;
    localparam int HW = 80;
    localparam int VL = 240;
    localparam int LS = 128;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sof;
        logic          eol;
        logic          eof;
    } exp_word_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] baseAddr;
    logic          busy, done, csn, wen, ovalid, ordy, osof, oeol, oeof;
    logic [AW-1:0] addr;
    logic [DW-1:0] dout, odata;

    logic [DW-1:0] mem [0:65535];
    exp_word_t     expWords[$];
    logic [AW-1:0] expAddr[$];

    int checkCnt = 0;
    int passCnt  = 0;
    int readyPct = 100;
    int total = 0, issued = 0, popped = 0;
    bit monEn = 0, active = 0, startPending = 0, doneDue = 0, afterDone = 0;
    bit frameDone = 0, prevStall = 0;

    frame_memory_reader #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .H_WORDS     (HW),
        .V_LINES     (VL),
        .LINE_STRIDE (LS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
`ifdef FRM_RD_BASE_EN
        .base_addr (baseAddr),
`endif
        .busy      (busy),
        .done      (done),
        .csn       (csn),
        .wen       (wen),
        .addr      (addr),
        .dout      (dout),
        .odata     (odata),
        .ovalid    (ovalid),
        .ordy      (ordy),
        .osof      (osof),
        .oeol      (oeol),
        .oeof      (oeof)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checkCnt++;
        if (got === exp) passCnt++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_csn"}, csn, 1);
        checkOutput({tag, "_wen"}, wen, 1);
        checkOutput({tag, "_addr"}, addr, 0);
        checkOutput({tag, "_ovalid"}, ovalid, 0);
        checkOutput({tag, "_odata"}, odata, 0);
        checkOutput({tag, "_osof"}, osof, 0);
        checkOutput({tag, "_oeol"}, oeol, 0);
        checkOutput({tag, "_oeof"}, oeof, 0);
    endtask

    // Builds the expected frame from the raster rules, then pulses start.
    task automatic applyStimulus(input logic [AW-1:0] base, input int pct);
        logic [AW-1:0] effBase;
        logic [AW-1:0] a;
        exp_word_t     w;
`ifdef FRM_RD_BASE_EN
        effBase = base;
`else
        effBase = '0;
`endif
        expWords.delete();
        expAddr.delete();
        for (int ln = 0; ln < VL; ln++) begin
            for (int c = 0; c < HW; c++) begin
                a      = AW'(int'(effBase) + ln * LS + c);
                w.data = mem[a];
                w.sof  = (ln == 0) && (c == 0);
                w.eol  = (c == HW - 1);
                w.eof  = (ln == VL - 1) && (c == HW - 1);
                expAddr.push_back(a);
                expWords.push_back(w);
            end
        end
        total     = expWords.size();
        issued    = 0;
        popped    = 0;
        frameDone = 0;
        readyPct  = pct;
        baseAddr  = base;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic pulseStart();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic waitFrame(input string tag, input int limit);
        int n = 0;
        while (!frameDone && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (!frameDone) checkOutput(tag, 0, 1);
    endtask

    // Synchronous SRAM: address sampled with CSN low, data one cycle later.
    initial begin
        logic          rdEn;
        logic [AW-1:0] rdA;
        dout = '0;
        forever begin
            @(negedge clk);
            rdEn = !csn;
            rdA  = addr;
            @(posedge clk);
            #1 dout = rdEn ? mem[rdA] : {$urandom, $urandom, $urandom};
        end
    end

    initial begin
        ordy = 1'b0;
        forever begin
            @(posedge clk);
            #1 ordy = ($urandom_range(99) < readyPct);
        end
    end

    // Reference model: read credit, address order, word/tag order, done timing.
    always @(negedge clk) begin
        if (monEn) begin
            if (startPending) begin
                active       = 1;
                startPending = 0;
                checkOutput("busy_rise", busy, 1);
            end
            if (start && !active) startPending = 1;
            checkOutput("csn_credit", csn, !(active && issued < total && (issued - popped) < 4));
            checkOutput("wen", wen, 1);
            if (!csn) begin
                if (expAddr.size() == 0) checkOutput("extra_read", 1, 0);
                else checkOutput("read_addr", addr, expAddr.pop_front());
                issued++;
            end
            checkOutput("done", done, doneDue);
            if (doneDue) begin
                checkOutput("busy_at_done", busy, 1);
                doneDue   = 0;
                afterDone = 1;
                active    = 0;
            end else if (afterDone) begin
                checkOutput("busy_fall", busy, 0);
                afterDone = 0;
                frameDone = 1;
            end
            if (prevStall) checkOutput("valid_hold", ovalid, 1);
            if (ovalid) begin
                if (expWords.size() == 0) checkOutput("extra_word", 1, 0);
                else begin
                    checkOutput("word", {odata, osof, oeol, oeof}, expWords[0]);
                    if (ordy) begin
                        void'(expWords.pop_front());
                        popped++;
                        if (expWords.size() == 0) doneDue = 1;
                    end
                end
            end
            prevStall = ovalid && !ordy;
        end
    end

    initial begin
        int n;
        rst      = 1'b1;
        start    = 1'b0;
        baseAddr = '0;
        for (int i = 0; i < 65536; i++) mem[i] = {$urandom, $urandom, $urandom};

        repeat (3) @(negedge clk);
        checkResetValues("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        monEn = 1;

        $display("[TB] frame 1: ready held high, extra start while busy");
        applyStimulus(16'h8000, 100);
        repeat (200) @(posedge clk);
        pulseStart();
        waitFrame("frame1_timeout", 25000);
        repeat (20) @(negedge clk);

        $display("[TB] frame 2: 50%% ready, reset after word 5000");
        applyStimulus(16'hFFF0, 50);
        n = 0;
        while (popped < 5000 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (popped < 5000) checkOutput("reach_word_5000", 0, 1);
        @(posedge clk);
        #2 monEn = 0;
        rst = 1'b1;
        #1 checkResetValues("rst_async");
        @(negedge clk);
        checkResetValues("rst_mid");
        expWords.delete();
        expAddr.delete();
        active = 0; startPending = 0; doneDue = 0; afterDone = 0; prevStall = 0;
        issued = 0; popped = 0; total = 0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        monEn = 1;

        $display("[TB] frame 3: restart after reset, 70%% ready");
        applyStimulus(16'h0000, 70);
        waitFrame("frame3_timeout", 60000);
        repeat (10) @(negedge clk);

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
